div_unit: RTL and testbench

- Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions; sits in the execute stage beside the ALU.
- Takes operands after the forwarding muxes (forward_ae/forward_be selected values).
- Drives busy_o into the hazard unit, which stalls F/D/E while a division is in flight.
- Consumes flush_e from the hazard unit to kill an in-flight operation on a taken branch.

---
 rtl/div_if.sv | 26 ++
 rtl/div_unit.sv | 165 ++++++++++++++++
 tb/tb_div_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Issue/complete bus between the execute-stage pipeline and the iterative divider.
// The master drives operands and control; the slave (div_unit) returns busy, valid and result.
interface div_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic            flush_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic [4:0]      rd_i;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;

    modport master (
        output start_i, flush_i, op_i, a_i, b_i, rd_i,
        input  busy_o, valid_o, result_o, rd_o
    );

    modport slave (
        input  start_i, flush_i, op_i, a_i, b_i, rd_i,
        output busy_o, valid_o, result_o, rd_o
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU (IDLE -> CALC x32 -> FIN -> DONE).
// Optional macro DIV_EARLY_OUT_EN: finish at issue when |a| < |b|.
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input logic  clk_i,
    input logic  rst_i,
    div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [1:0]      op_q, op_d;
    logic [4:0]      tag_q, tag_d;
    logic [4:0]      rd_q, rd_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;

    logic            idle_or_done;
    logic            issue;
    logic            in_signed;
    logic            in_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            b_zero;
    logic            ovf;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
    assign issue        = idle_or_done && bus.start_i && !bus.flush_i;
    assign in_signed    = !bus.op_i[0];
    assign in_rem       = bus.op_i[1];
    assign a_neg        = in_signed && bus.a_i[XLEN-1];
    assign b_neg        = in_signed && bus.b_i[XLEN-1];
    assign a_mag        = a_neg ? -bus.a_i : bus.a_i;
    assign b_mag        = b_neg ? -bus.b_i : bus.b_i;
    assign b_zero       = (bus.b_i == '0);
    assign ovf          = in_signed && (bus.a_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b_i == '1);

    // Partial remainder never exceeds the divisor, so one extra bit holds the shifted value.
    assign rem_sh  = {rem_q, quo_q[XLEN-1]};
    assign trial   = rem_sh - {1'b0, dvs_q};
    assign quo_fix = (!op_q[0] && (sign_a_q ^ sign_b_q)) ? -quo_q : quo_q;
    assign rem_fix = (!op_q[0] && sign_a_q) ? -rem_q : rem_q;

    // CALC/FIN stall unconditionally; IDLE/DONE stall only while a new issue is accepted.
    assign bus.busy_o   = (state_q == CALC) || (state_q == FIN) || (bus.start_i && !bus.flush_i);
    assign bus.valid_o  = (state_q == DONE);
    assign bus.result_o = result_q;
    assign bus.rd_o     = rd_q;

    always_comb begin
        // NOTE: every _d takes its _q value first so no path through the case leaves a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        op_d     = op_q;
        tag_d    = tag_q;
        rd_d     = rd_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (issue) begin
                    op_d     = bus.op_i;
                    tag_d    = bus.rd_i;
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    dvs_d    = b_mag;
                    if (b_zero) begin
                        result_d = in_rem ? bus.a_i : '1;
                        rd_d     = bus.rd_i;
                        state_d  = DONE;
                    end else if (ovf) begin
                        result_d = in_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        rd_d     = bus.rd_i;
                        state_d  = DONE;
`ifdef DIV_EARLY_OUT_EN
                    end else if (a_mag < b_mag) begin
                        result_d = in_rem ? bus.a_i : '0;
                        rd_d     = bus.rd_i;
                        state_d  = DONE;
`endif
                    end else begin
                        rem_d   = '0;
                        quo_d   = a_mag;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else begin
                    if (!trial[XLEN]) begin
                        rem_d = trial[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN-1)) state_d = FIN;
                end
            end
            FIN: begin
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else begin
                    result_d = op_q[1] ? rem_fix : quo_fix;
                    rd_d     = tag_q;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all datapath registers are reset too, so a reset mid-operation leaves no stale result visible.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            op_q     <= '0;
            tag_q    <= '0;
            rd_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            rd_q     <= rd_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, results, flush, reset and back-to-back issue.
module tb_div_unit;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    div_if #(.XLEN(32)) bus ();

    div_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 34;
`endif

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.rd_i    = rd;
        bus.start_i = 1'b1;
    endtask

    // Called at a negedge right after issue(); returns at the negedge of the valid cycle.
    task automatic wait_done(output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        #1;
        if (bus.busy_o !== 1'b1) busy_ok = 1'b0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus.start_i = 1'b0;
            if (bus.valid_o === 1'b1) break;
            if (bus.busy_o !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.valid_o); end
        n_cmp++; if (bus.result_o !== 32'h0) begin n_err++; $display("FAIL rst_result: got %h want 0", bus.result_o); end
        n_cmp++; if (bus.rd_o !== 5'd0) begin n_err++; $display("FAIL rst_rd: got %0d want 0", bus.rd_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy_o); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL rst_rel_valid: got %b want 0", bus.valid_o); end
    endtask

    task automatic test_divu_remu();
        int   lat;
        logic bok;
        issue(OP_DIVU, 32'd100, 32'd7, 5'd5);
        wait_done(lat, bok);
        n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL divu_lat: got %0d want 34", lat); end
        n_cmp++; if (bus.result_o !== 32'd14) begin n_err++; $display("FAIL divu_res: got %h want %h", bus.result_o, 32'd14); end
        n_cmp++; if (bus.rd_o !== 5'd5) begin n_err++; $display("FAIL divu_rd: got %0d want 5", bus.rd_o); end
        n_cmp++; if (bok !== 1'b1) begin n_err++; $display("FAIL divu_busy: got %b want 1", bok); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL done_busy: got %b want 0", bus.busy_o); end
        @(negedge clk);
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL valid_pulse: got %b want 0", bus.valid_o); end
        n_cmp++; if (bus.result_o !== 32'd14) begin n_err++; $display("FAIL res_hold: got %h want %h", bus.result_o, 32'd14); end
        issue(OP_REMU, 32'd100, 32'd7, 5'd6);
        wait_done(lat, bok);
        n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL remu_lat: got %0d want 34", lat); end
        n_cmp++; if (bus.result_o !== 32'd2) begin n_err++; $display("FAIL remu_res: got %h want %h", bus.result_o, 32'd2); end
        n_cmp++; if (bus.rd_o !== 5'd6) begin n_err++; $display("FAIL remu_rd: got %0d want 6", bus.rd_o); end
        n_cmp++; if (bok !== 1'b1) begin n_err++; $display("FAIL remu_busy: got %b want 1", bok); end
        @(negedge clk);
    endtask

    task automatic test_signed();
        logic [1:0]  ops [6] = '{OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIVU, OP_REMU};
        logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h10, 32'h10};
        logic [31:0] exp [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'h0FFF_FFFF, 32'hF};
        int   lat;
        logic bok;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i], 5'(i + 16));
            wait_done(lat, bok);
            n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL sgn%0d_lat: got %0d want 34", i, lat); end
            n_cmp++; if (bus.result_o !== exp[i]) begin n_err++; $display("FAIL sgn%0d_res: got %h want %h", i, bus.result_o, exp[i]); end
            n_cmp++; if (bus.rd_o !== 5'(i + 16)) begin n_err++; $display("FAIL sgn%0d_rd: got %0d want %0d", i, bus.rd_o, i + 16); end
            @(negedge clk);
        end
    endtask

    task automatic test_special();
        logic [1:0]  ops [5] = '{OP_DIV, OP_REMU, OP_DIV, OP_REM, OP_DIVU};
        logic [31:0] as  [5] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [5] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0};
        int          elat[5] = '{1, 1, 1, 1, EARLY_LAT};
        int   lat;
        logic bok;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i], 5'(i + 8));
            wait_done(lat, bok);
            n_cmp++; if (lat !== elat[i]) begin n_err++; $display("FAIL spc%0d_lat: got %0d want %0d", i, lat, elat[i]); end
            n_cmp++; if (bus.result_o !== exp[i]) begin n_err++; $display("FAIL spc%0d_res: got %h want %h", i, bus.result_o, exp[i]); end
            n_cmp++; if (bus.rd_o !== 5'(i + 8)) begin n_err++; $display("FAIL spc%0d_rd: got %0d want %0d", i, bus.rd_o, i + 8); end
            @(negedge clk);
        end
    endtask

    task automatic test_flush();
        logic [31:0] prev_res;
        logic [4:0]  prev_rd;
        int   nval;
        int   lat;
        logic bok;
        prev_res = bus.result_o;
        prev_rd  = bus.rd_o;
        issue(OP_DIVU, 32'd1000, 32'd3, 5'd3);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (10) @(negedge clk);
        bus.flush_i = 1'b1;
        #1;
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL flush_busy_calc: got %b want 1", bus.busy_o); end
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL flush_busy_after: got %b want 0", bus.busy_o); end
        n_cmp++; if (bus.result_o !== prev_res) begin n_err++; $display("FAIL flush_res_hold: got %h want %h", bus.result_o, prev_res); end
        n_cmp++; if (bus.rd_o !== prev_rd) begin n_err++; $display("FAIL flush_rd_hold: got %0d want %0d", bus.rd_o, prev_rd); end
        nval = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid_o !== 1'b0) nval++;
        end
        n_cmp++; if (nval !== 0) begin n_err++; $display("FAIL flush_no_valid: got %0d valid cycles want 0", nval); end
        issue(OP_DIVU, 32'd9, 32'd3, 5'd12);
        bus.flush_i = 1'b1;
        #1;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL flush_start_busy: got %b want 0", bus.busy_o); end
        nval = 0;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) nval++;
        end
        n_cmp++; if (nval !== 0) begin n_err++; $display("FAIL flush_over_start: got %0d active cycles want 0", nval); end
        issue(OP_DIVU, 32'd9, 32'd3, 5'd12);
        wait_done(lat, bok);
        n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL post_flush_lat: got %0d want 34", lat); end
        n_cmp++; if (bus.result_o !== 32'd3) begin n_err++; $display("FAIL post_flush_res: got %h want %h", bus.result_o, 32'd3); end
        n_cmp++; if (bus.rd_o !== 5'd12) begin n_err++; $display("FAIL post_flush_rd: got %0d want 12", bus.rd_o); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops [4] = '{OP_DIVU, OP_DIVU, OP_DIV, OP_REMU};
        logic [31:0] as  [4] = '{32'd9, 32'd100, 32'd5, 32'd100};
        logic [31:0] bs  [4] = '{32'd3, 32'd7, 32'd0, 32'd7};
        logic [31:0] exp [4] = '{32'd3, 32'd14, 32'hFFFF_FFFF, 32'd2};
        int          elat[4] = '{34, 34, 1, 34};
        int   lat;
        logic bok;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 5'(i + 1));
            wait_done(lat, bok);
            n_cmp++; if (lat !== elat[i]) begin n_err++; $display("FAIL b2b%0d_lat: got %0d want %0d", i, lat, elat[i]); end
            n_cmp++; if (bus.result_o !== exp[i]) begin n_err++; $display("FAIL b2b%0d_res: got %h want %h", i, bus.result_o, exp[i]); end
            n_cmp++; if (bus.rd_o !== 5'(i + 1)) begin n_err++; $display("FAIL b2b%0d_rd: got %0d want %0d", i, bus.rd_o, i + 1); end
            n_cmp++; if (bok !== 1'b1) begin n_err++; $display("FAIL b2b%0d_busy: got %b want 1", i, bok); end
        end
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        int nval;
        issue(OP_DIV, 32'd100, 32'd7, 5'd9);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.result_o !== 32'h0) begin n_err++; $display("FAIL rstmid_res: got %h want 0", bus.result_o); end
        n_cmp++; if (bus.rd_o !== 5'd0) begin n_err++; $display("FAIL rstmid_rd: got %0d want 0", bus.rd_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", bus.busy_o); end
        @(negedge clk);
        rst  = 1'b0;
        nval = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid_o !== 1'b0) nval++;
        end
        n_cmp++; if (nval !== 0) begin n_err++; $display("FAIL rstmid_no_valid: got %0d valid cycles want 0", nval); end
    endtask

    task automatic test_early_out();
        int   lat;
        logic bok;
        issue(OP_DIVU, 32'd3, 32'd10, 5'd4);
        wait_done(lat, bok);
        n_cmp++; if (lat !== EARLY_LAT) begin n_err++; $display("FAIL early_divu_lat: got %0d want %0d", lat, EARLY_LAT); end
        n_cmp++; if (bus.result_o !== 32'd0) begin n_err++; $display("FAIL early_divu_res: got %h want 0", bus.result_o); end
        @(negedge clk);
        issue(OP_REM, 32'hFFFF_FFFD, 32'd10, 5'd7);
        wait_done(lat, bok);
        n_cmp++; if (lat !== EARLY_LAT) begin n_err++; $display("FAIL early_rem_lat: got %0d want %0d", lat, EARLY_LAT); end
        n_cmp++; if (bus.result_o !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL early_rem_res: got %h want fffffffd", bus.result_o); end
        n_cmp++; if (bus.rd_o !== 5'd7) begin n_err++; $display("FAIL early_rem_rd: got %0d want 7", bus.rd_o); end
        @(negedge clk);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        clk         = 1'b0;
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.op_i    = 2'b00;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.rd_i    = '0;
        test_reset();
        test_divu_remu();
        test_signed();
        test_special();
        test_flush();
        test_back_to_back();
        test_rst_mid();
        test_early_out();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
